iso_link_sequencer: RTL and testbench
=====================================

ISO_LINK_SEQUENCER -- requirements
Module: iso_link_sequencer

Interface
REQ-001 SCLK_HALF, 2, clk cycles per mclk half-period; legal range 1..255.
REQ-002 POLL_PERIOD, 1024, idle clk cycles between auto-poll frames; used only under ISO_AUTOPOLL_EN.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  frame request; sampled every cycle.
REQ-006 busy  out  1  high while a frame is in progress.
REQ-007 done  out  1  one-cycle pulse at frame end.
REQ-008 dmcs_in, amcs_in, clksel_in  in  4 each  per-slot values for the outgoing chains.
REQ-009 mclk, srclk  out  1 each  serial shift clock and parallel latch strobe to the isolator.
REQ-010 dmcs, amcs, clksel  out  1 each  serial data for the three outgoing chains.
REQ-011 dirchan, aovf  in  1 each  serial data from the two incoming chains.
REQ-012 slot_dir, slot_chan, aovfl, aovfr  out  4 each  deserialized slot status.
REQ-013 status_valid  out  1  one-cycle pulse when the status outputs update.

Function
REQ-014 States SHALL be IDLE, SHIFT, LATCH and GUARD; the only transitions SHALL be IDLE->SHIFT on a start, SHIFT->LATCH after 8 bits, LATCH->GUARD after SCLK_HALF cycles, and GUARD->IDLE after SCLK_HALF cycles.
REQ-015 A start SHALL occur in IDLE when req=1 or pending=1; on a start, dmcs_in, amcs_in and clksel_in are captured into shadow registers.
REQ-016 req=1 while busy SHALL set pending; any number of such requests SHALL yield exactly one extra frame, which starts in the cycle after done.
REQ-017 SHIFT SHALL send 8 bits per chain, each bit as SCLK_HALF cycles with mclk=0 followed by SCLK_HALF cycles with mclk=1.
REQ-018 Outgoing bits SHALL be 0,0,0,0 followed by shadow[3] down to shadow[0]; each bit is driven on entry to its low half and held through its high half.
REQ-019 dirchan and aovf SHALL be sampled on the clk edge that drives mclk 0->1; the first bit sampled is bit 7.
REQ-020 The dirchan vector SHALL be {slot_chan[3:0], slot_dir[3:0]}.
REQ-021 The aovf vector SHALL be {aovfr[3],aovfl[3],aovfr[2],aovfl[2],aovfr[1],aovfl[1],aovfr[0],aovfl[0]}.
REQ-022 Status outputs SHALL update and status_valid SHALL pulse together on the first cycle of LATCH; the status reflects the parallel load made by the previous frame's srclk.
REQ-023 In LATCH, srclk=1 and mclk=0; in GUARD, srclk=0 and mclk=0; serial outputs SHALL be 0 outside SHIFT.
REQ-024 busy SHALL be high for exactly 18*SCLK_HALF cycles, beginning the cycle after the start; done pulses on the cycle busy falls.

Reset
REQ-025 On reset assertion, without waiting for clk: every output SHALL be 0, state IDLE, pending, shadow registers and the poll counter cleared.
REQ-026 Reset during SHIFT SHALL abort the frame with no srclk pulse, so the isolator latches keep their prior values.

Configuration
REQ-027 With ISO_AUTOPOLL_EN defined, an IDLE counter SHALL raise an internal start after POLL_PERIOD consecutive idle cycles and clear on every start; without the macro, frames start only from req and no counter exists.

Verification
REQ-028 SCLK_HALF=2, reset, req pulse with dmcs_in=4'b0101 -> dmcs bits 0,0,0,0,0,1,0,1; srclk high 2 cycles; busy high 36 cycles; one done pulse.
REQ-029 Bench drives dirchan 1,0,1,0,0,0,1,1 and aovf 0,0,0,0,0,0,0,1 -> {slot_chan,slot_dir}=8'hA3, aovfl[0]=1, one status_valid pulse.
REQ-030 Three req pulses during one busy frame -> exactly two frames in total, the second starting the cycle after done.
REQ-031 Reset asserted at bit 3 of SHIFT -> mclk, srclk and all outputs 0 immediately; no srclk pulse in the aborted frame.
REQ-032 ISO_AUTOPOLL_EN defined, POLL_PERIOD=100, SCLK_HALF=2, no req -> frame starts every 136 cycles; without the macro, no frame starts in 1000 cycles.
REQ-033 SCLK_HALF=1 with req held high -> back-to-back frames, each 18 cycles busy, status_valid once per frame.

Source files
------------

// File: rtl/iso_link_sequencer.sv
// iso_link_sequencer: frames serial traffic across a digital isolator.
// Each frame shifts 8 bits out on three chains (dmcs, amcs, clksel) and
// 8 bits in on two chains (dirchan, aovf). After the shift it pulses srclk
// for the parallel latch and then waits out a guard interval.
// Optional feature macro: ISO_AUTOPOLL_EN adds an idle counter that starts
// a frame after POLL_PERIOD idle cycles. Without the macro only req starts frames.
//
// state | meaning
// IDLE  | waiting for req, pending or an auto-poll start
// SHIFT | 8 bits, each SCLK_HALF clk low then SCLK_HALF clk high on mclk
// LATCH | srclk high for SCLK_HALF cycles; status published on entry
// GUARD | SCLK_HALF quiet cycles before returning to IDLE
module iso_link_sequencer #(
  parameter int SCLK_HALF = 2
`ifdef ISO_AUTOPOLL_EN
  , parameter int POLL_PERIOD = 1024
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       busy,
  output logic       done,
  input  logic [3:0] dmcs_in,
  input  logic [3:0] amcs_in,
  input  logic [3:0] clksel_in,
  output logic       mclk,
  output logic       srclk,
  output logic       dmcs,
  output logic       amcs,
  output logic       clksel,
  input  logic       dirchan,
  input  logic       aovf,
  output logic [3:0] slot_dir,
  output logic [3:0] slot_chan,
  output logic [3:0] aovfl,
  output logic [3:0] aovfr,
  output logic       status_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GUARD} state_t;

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  state_t      state, state_nxt;
  logic [7:0]  half_cnt;
  logic [2:0]  bit_idx;
  logic        phase;
  logic        pending;
  logic        start;
  logic        poll_start;
  logic        half_tc;
  logic        out_sel;
  logic [3:0]  sh_dmcs, sh_amcs, sh_clksel;
  logic [7:0]  dir_sr, aovf_sr;

  assign half_tc = (half_cnt == 8'd0);
  assign start   = (state == IDLE) && (req || pending || poll_start);

`ifdef ISO_AUTOPOLL_EN
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  logic [PW-1:0] poll_cnt;

  assign poll_start = (state == IDLE) && (poll_cnt == POLL_LAST);

  // Counts consecutive idle cycles; any start clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               poll_cnt <= '0;
    else if (start)          poll_cnt <= '0;
    else if (state == IDLE)  poll_cnt <= poll_cnt + 1'b1;
  end
`else
  assign poll_start = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and isolator-facing outputs, all decoded from flops.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    mclk      = 1'b0;
    srclk     = 1'b0;
    dmcs      = 1'b0;
    amcs      = 1'b0;
    clksel    = 1'b0;
    // Upper four bits of every outgoing byte are zero padding.
    out_sel   = ~bit_idx[2];
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        mclk   = phase;
        dmcs   = out_sel & sh_dmcs[bit_idx[1:0]];
        amcs   = out_sel & sh_amcs[bit_idx[1:0]];
        clksel = out_sel & sh_clksel[bit_idx[1:0]];
        if (half_tc && phase && (bit_idx == 3'd0)) state_nxt = LATCH;
      end
      LATCH: begin
        srclk = 1'b1;
        if (half_tc) state_nxt = GUARD;
      end
      GUARD: if (half_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Half-period down-counter, mclk phase and bit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt <= 8'd0;
      bit_idx  <= 3'd0;
      phase    <= 1'b0;
    end else if (state_nxt != state) begin
      half_cnt <= HALF_LAST;
      bit_idx  <= 3'd7;
      phase    <= 1'b0;
    end else if (state != IDLE) begin
      if (half_tc) begin
        half_cnt <= HALF_LAST;
        if (state == SHIFT) begin
          phase <= ~phase;
          if (phase) bit_idx <= bit_idx - 3'd1;
        end
      end else begin
        half_cnt <= half_cnt - 8'd1;
      end
    end
  end

  // Pending request and shadow capture of the outgoing slot values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      sh_dmcs   <= 4'd0;
      sh_amcs   <= 4'd0;
      sh_clksel <= 4'd0;
    end else if (start) begin
      pending   <= 1'b0;
      sh_dmcs   <= dmcs_in;
      sh_amcs   <= amcs_in;
      sh_clksel <= clksel_in;
    end else if (req && busy) begin
      pending   <= 1'b1;
    end
  end

  // Incoming chains are sampled on the edge that raises mclk, MSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_sr  <= 8'd0;
      aovf_sr <= 8'd0;
    end else if ((state == SHIFT) && half_tc && !phase) begin
      dir_sr  <= {dir_sr[6:0], dirchan};
      aovf_sr <= {aovf_sr[6:0], aovf};
    end
  end

  // Status publish on LATCH entry, and the end-of-frame done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_dir     <= 4'd0;
      slot_chan    <= 4'd0;
      aovfl        <= 4'd0;
      aovfr        <= 4'd0;
      status_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      done         <= (state == GUARD) && (state_nxt == IDLE);
      if ((state == SHIFT) && (state_nxt == LATCH)) begin
        slot_chan    <= dir_sr[7:4];
        slot_dir     <= dir_sr[3:0];
        aovfr        <= {aovf_sr[7], aovf_sr[5], aovf_sr[3], aovf_sr[1]};
        aovfl        <= {aovf_sr[6], aovf_sr[4], aovf_sr[2], aovf_sr[0]};
        status_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iso_link_sequencer.sv
// Bench for iso_link_sequencer: table-driven frames on an SCLK_HALF=2 instance,
// plus pending, mid-shift reset, SCLK_HALF=1 back-to-back and idle/auto-poll
// sequences on dedicated instances.
module tb_iso_link_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // instance a: SCLK_HALF=2
  logic       req_a = 1'b0;
  logic [3:0] dmcs_in_a = '0, amcs_in_a = '0, clksel_in_a = '0;
  logic       dirchan_a = 1'b0, aovf_a = 1'b0;
  logic       busy_a, done_a, mclk_a, srclk_a, dmcs_a, amcs_a, clksel_a, sv_a;
  logic [3:0] slot_dir_a, slot_chan_a, aovfl_a, aovfr_a;

  // instance b: SCLK_HALF=1
  logic       req_b = 1'b0;
  logic       busy_b, done_b, mclk_b, srclk_b, dmcs_b, amcs_b, clksel_b, sv_b;
  logic [3:0] slot_dir_b, slot_chan_b, aovfl_b, aovfr_b;

  // instance c: SCLK_HALF=2, never requested
  logic       busy_c, done_c, mclk_c, srclk_c, dmcs_c, amcs_c, clksel_c, sv_c;
  logic [3:0] slot_dir_c, slot_chan_c, aovfl_c, aovfr_c;

  iso_link_sequencer #(.SCLK_HALF(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .busy(busy_a), .done(done_a),
    .dmcs_in(dmcs_in_a), .amcs_in(amcs_in_a), .clksel_in(clksel_in_a),
    .mclk(mclk_a), .srclk(srclk_a), .dmcs(dmcs_a), .amcs(amcs_a), .clksel(clksel_a),
    .dirchan(dirchan_a), .aovf(aovf_a),
    .slot_dir(slot_dir_a), .slot_chan(slot_chan_a), .aovfl(aovfl_a), .aovfr(aovfr_a),
    .status_valid(sv_a));

  iso_link_sequencer #(.SCLK_HALF(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .busy(busy_b), .done(done_b),
    .dmcs_in(4'h0), .amcs_in(4'h0), .clksel_in(4'h0),
    .mclk(mclk_b), .srclk(srclk_b), .dmcs(dmcs_b), .amcs(amcs_b), .clksel(clksel_b),
    .dirchan(1'b0), .aovf(1'b0),
    .slot_dir(slot_dir_b), .slot_chan(slot_chan_b), .aovfl(aovfl_b), .aovfr(aovfr_b),
    .status_valid(sv_b));

`ifdef ISO_AUTOPOLL_EN
  iso_link_sequencer #(.SCLK_HALF(2), .POLL_PERIOD(100)) dut_c (
`else
  iso_link_sequencer #(.SCLK_HALF(2)) dut_c (
`endif
    .clk(clk), .reset(reset), .req(1'b0), .busy(busy_c), .done(done_c),
    .dmcs_in(4'h0), .amcs_in(4'h0), .clksel_in(4'h0),
    .mclk(mclk_c), .srclk(srclk_c), .dmcs(dmcs_c), .amcs(amcs_c), .clksel(clksel_c),
    .dirchan(1'b0), .aovf(1'b0),
    .slot_dir(slot_dir_c), .slot_chan(slot_chan_c), .aovfl(aovfl_c), .aovfr(aovfr_c),
    .status_valid(sv_c));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // monitor state
  int cyc = 0;
  int busy_cyc_a = 0, srclk_cyc_a = 0, done_cnt_a = 0, done_fall_a = 0, sv_cnt_a = 0;
  int starts_a = 0, rise_a = 0, run_a = 0, last_run_a = 0, last_done_a = 0, last_gap_a = 0;
  logic [7:0] cap_dmcs = '0, cap_amcs = '0, cap_clksel = '0;
  logic [7:0] dir_seq = '0, aovf_seq = '0;
  logic prev_busy_a = 1'b0, prev_mclk_a = 1'b0;
  int starts_b = 0, run_b = 0, bad_run_b = 0, sv_cnt_b = 0, last_done_b = 0, bad_gap_b = 0;
  logic prev_busy_b = 1'b0;
  int starts_c = 0, last_start_c = 0, bad_int_c = 0;
  logic c_valid = 1'b0, prev_busy_c = 1'b0;

  // Observes all instances on the falling edge and drives instance a's incoming chains.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (busy_a) begin busy_cyc_a++; run_a++; end
      if (busy_a && !prev_busy_a) begin starts_a++; last_gap_a = cyc - last_done_a; end
      if (!busy_a && prev_busy_a) begin
        last_run_a = run_a;
        if (done_a) done_fall_a++;
      end
      if (!busy_a) run_a = 0;
      if (srclk_a) srclk_cyc_a++;
      if (done_a) begin done_cnt_a++; last_done_a = cyc; end
      if (sv_a) sv_cnt_a++;
      if (mclk_a && !prev_mclk_a) begin
        cap_dmcs   = {cap_dmcs[6:0], dmcs_a};
        cap_amcs   = {cap_amcs[6:0], amcs_a};
        cap_clksel = {cap_clksel[6:0], clksel_a};
        rise_a++;
      end
      if (!busy_a) rise_a = 0;
      dirchan_a = (rise_a < 8) ? dir_seq[3'(7 - rise_a)] : 1'b0;
      aovf_a    = (rise_a < 8) ? aovf_seq[3'(7 - rise_a)] : 1'b0;
      prev_busy_a = busy_a;
      prev_mclk_a = mclk_a;

      if (busy_b) run_b++;
      if (busy_b && !prev_busy_b) begin
        if (starts_b > 0 && (cyc - last_done_b) != 1) bad_gap_b++;
        starts_b++;
      end
      if (!busy_b && prev_busy_b && run_b != 18) bad_run_b++;
      if (!busy_b) run_b = 0;
      if (done_b) last_done_b = cyc;
      if (sv_b) sv_cnt_b++;
      prev_busy_b = busy_b;

      if (reset) c_valid = 1'b0;
      if (busy_c && !prev_busy_c) begin
        if (c_valid && (cyc - last_start_c) != 136) bad_int_c++;
        starts_c++;
        last_start_c = cyc;
        c_valid = 1'b1;
      end
      prev_busy_c = busy_c;
    end
  end

  typedef struct {
    logic [3:0] d, a, c;
    logic [7:0] dir, av;
    logic [7:0] ed, ea, ec;
    logic [3:0] echan, edir, el, er;
  } vec_t;

  vec_t vt[4];

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (busy_a && n < 300) begin tick(); n++; end
    check(name, {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    int b0, s0, d0, f0, v0, st0;
    int n;

    vt[0] = '{4'b0101, 4'b0000, 4'b1111, 8'b10100011, 8'b00000001,
              8'b00000101, 8'b00000000, 8'b00001111, 4'hA, 4'h3, 4'b0001, 4'b0000};
    vt[1] = '{4'b1010, 4'b0011, 4'b1000, 8'b01011100, 8'b10000000,
              8'b00001010, 8'b00000011, 8'b00001000, 4'h5, 4'hC, 4'b0000, 4'b1000};
    vt[2] = '{4'b1111, 4'b1001, 4'b0110, 8'b11110000, 8'b01010101,
              8'b00001111, 8'b00001001, 8'b00000110, 4'hF, 4'h0, 4'b1111, 4'b0000};
    vt[3] = '{4'b0000, 4'b1111, 4'b0001, 8'b00000001, 8'b10101010,
              8'b00000000, 8'b00001111, 8'b00000001, 4'h0, 4'h1, 4'b0000, 4'b1111};

    #2 reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {8'd0, busy_a, done_a, mclk_a, srclk_a, dmcs_a, amcs_a, clksel_a, sv_a,
           slot_dir_a, slot_chan_a, aovfl_a, aovfr_a}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      dmcs_in_a = vt[i].d; amcs_in_a = vt[i].a; clksel_in_a = vt[i].c;
      dir_seq = vt[i].dir; aovf_seq = vt[i].av;
      b0 = busy_cyc_a; s0 = srclk_cyc_a; d0 = done_cnt_a; f0 = done_fall_a; v0 = sv_cnt_a;
      req_a = 1'b1;
      tick();
      req_a = 1'b0;
      dmcs_in_a = ~vt[i].d; amcs_in_a = ~vt[i].a; clksel_in_a = ~vt[i].c;
      wait_idle_a($sformatf("v%0d_frame_end", i));
      repeat (3) tick();
      check($sformatf("v%0d_dmcs_bits", i), cap_dmcs, vt[i].ed);
      check($sformatf("v%0d_amcs_bits", i), cap_amcs, vt[i].ea);
      check($sformatf("v%0d_clksel_bits", i), cap_clksel, vt[i].ec);
      check($sformatf("v%0d_chan_dir", i), {slot_chan_a, slot_dir_a}, {vt[i].echan, vt[i].edir});
      check($sformatf("v%0d_aovfl", i), aovfl_a, vt[i].el);
      check($sformatf("v%0d_aovfr", i), aovfr_a, vt[i].er);
      check($sformatf("v%0d_busy_cycles", i), busy_cyc_a - b0, 36);
      check($sformatf("v%0d_busy_run", i), last_run_a, 36);
      check($sformatf("v%0d_srclk_cycles", i), srclk_cyc_a - s0, 2);
      check($sformatf("v%0d_done_pulses", i), done_cnt_a - d0, 1);
      check($sformatf("v%0d_done_at_fall", i), done_fall_a - f0, 1);
      check($sformatf("v%0d_status_valid", i), sv_cnt_a - v0, 1);
    end

    // three requests inside one busy frame -> exactly one extra frame
    dir_seq = 8'hA3; aovf_seq = 8'h01;
    st0 = starts_a; d0 = done_cnt_a;
    req_a = 1'b1; tick(); req_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) tick();
      req_a = 1'b1; tick(); req_a = 1'b0;
    end
    repeat (120) tick();
    check("pend_frames", starts_a - st0, 2);
    check("pend_done_pulses", done_cnt_a - d0, 2);
    check("pend_start_gap", last_gap_a, 1);
    check("pend_status", {slot_chan_a, slot_dir_a}, 8'hA3);

    // reset in the middle of the shift: bit index 3 carries shadow[3]=1
    dmcs_in_a = 4'b1111; amcs_in_a = 4'b1111; clksel_in_a = 4'b1111;
    s0 = srclk_cyc_a; v0 = sv_cnt_a;
    req_a = 1'b1; tick(); req_a = 1'b0;
    n = 0;
    while (!(rise_a == 5 && mclk_a) && n < 200) begin tick(); n++; end
    check("abort_pre_state", {29'd0, mclk_a, dmcs_a, busy_a}, 32'h7);
    reset = 1'b1;
    #1;
    check("abort_outputs",
          {8'd0, busy_a, done_a, mclk_a, srclk_a, dmcs_a, amcs_a, clksel_a, sv_a,
           slot_dir_a, slot_chan_a, aovfl_a, aovfr_a}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();
    check("abort_no_srclk", srclk_cyc_a - s0, 0);
    check("abort_no_status", sv_cnt_a - v0, 0);
    check("abort_stays_idle", {31'd0, busy_a}, 32'd0);

    // SCLK_HALF=1 with req held for 40 cycles: 3 direct starts + 1 from pending
    req_b = 1'b1;
    repeat (40) tick();
    req_b = 1'b0;
    repeat (80) tick();
    check("b2b_frames", starts_b, 4);
    check("b2b_bad_runs", bad_run_b, 0);
    check("b2b_status_valid", sv_cnt_b, 4);
    check("b2b_bad_gaps", bad_gap_b, 0);

    // idle behaviour with no requests
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    st0 = starts_c;
    repeat (1000) tick();
`ifdef ISO_AUTOPOLL_EN
    check("poll_frames", starts_c - st0, 7);
    check("poll_interval_errors", bad_int_c, 0);
`else
    check("idle_no_frames", starts_c - st0, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
